// File: rtl/store_data_buffer_if.sv
// Store-data buffer bus: StDataUOp write lanes, branch/flush, head/commit port and forwarding lookup.
// The producer/commit side uses the master modport; the buffer itself uses the slave modport.
interface store_data_buffer_if #(
  parameter int WIDTH  = 2,
  parameter int SQN_W  = 7,
  parameter int DATA_W = 32
);
  logic [WIDTH-1:0]             uop_valid;
  logic [WIDTH-1:0][SQN_W-1:0]  uop_sqn;
  logic [WIDTH-1:0][DATA_W-1:0] uop_data;

  logic                         branch_taken;
  logic                         branch_flush;
  logic [SQN_W-1:0]             branch_sqn;

  logic                         deq;
  logic [SQN_W-1:0]             head_sqn;
  logic                         head_valid;
  logic [DATA_W-1:0]            head_data;

  logic [SQN_W-1:0]             rd_sqn;
  logic                         rd_valid;
  logic [DATA_W-1:0]            rd_data;

  logic                         err;

  modport master (
    output uop_valid, uop_sqn, uop_data,
    output branch_taken, branch_flush, branch_sqn,
    output deq, rd_sqn,
    input  head_sqn, head_valid, head_data,
    input  rd_valid, rd_data, err
  );

  modport slave (
    input  uop_valid, uop_sqn, uop_data,
    input  branch_taken, branch_flush, branch_sqn,
    input  deq, rd_sqn,
    output head_sqn, head_valid, head_data,
    output rd_valid, rd_data, err
  );
endinterface

// File: rtl/store_data_buffer.sv
// Per-store-queue-slot data buffer: stages incoming store data one cycle, then writes it into the slot array.
// Optional macro STDATA_BYPASS_EN lets the head and lookup ports also see live stage entries.
module store_data_buffer #(
  parameter int WIDTH   = 2,
  parameter int SQ_SIZE = 16,
  parameter int SQN_W   = 7,
  parameter int DATA_W  = 32
) (
  input logic                clk,
  input logic                rst_n,
  store_data_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(SQ_SIZE);

  typedef logic [SQN_W-1:0]  sqn_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Wrapping order: a is strictly younger than b when the signed distance is positive.
  function automatic logic is_younger(input sqn_t a, input sqn_t b);
    sqn_t d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  // With a power-of-two window, 0 <= s - head < SQ_SIZE means the upper distance bits are all zero.
  function automatic logic in_window(input sqn_t s, input sqn_t h);
    sqn_t d;
    d = s - h;
    return d[SQN_W-1:IDX_W] == '0;
  endfunction

  function automatic logic is_killed(input sqn_t s, input logic taken, input logic flush,
                                     input sqn_t bsqn);
    return taken && (flush || is_younger(s, bsqn));
  endfunction

  logic [SQ_SIZE-1:0] slot_valid;
  sqn_t               slot_sqn  [SQ_SIZE];
  data_t              slot_data [SQ_SIZE];

  logic [WIDTH-1:0]   stage_valid;
  sqn_t               stage_sqn  [WIDTH];
  data_t              stage_data [WIDTH];

  sqn_t               head;
  logic               err;

  idx_t               head_idx;
  idx_t               rd_idx;
  idx_t               lane_slot [WIDTH];
  logic [WIDTH-1:0]   lane_killed;
  logic [WIDTH-1:0]   lane_live;
  logic [WIDTH-1:0]   lane_write;
  logic               head_hit;
  data_t              head_word;
  logic               rd_hit;
  data_t              rd_word;
  logic               deq_fire;
  logic               err_set;

  assign head_idx = head[IDX_W-1:0];
  assign rd_idx   = bus.rd_sqn[IDX_W-1:0];

  // A stage entry is live when it survives this cycle's branch and sits inside the current window.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      lane_slot[i]   = stage_sqn[i][IDX_W-1:0];
      lane_killed[i] = is_killed(stage_sqn[i], bus.branch_taken, bus.branch_flush, bus.branch_sqn);
      lane_live[i]   = stage_valid[i] && !lane_killed[i] && in_window(stage_sqn[i], head);
    end
  end

  always_comb begin
    head_hit  = slot_valid[head_idx] && (slot_sqn[head_idx] == head);
    head_word = slot_data[head_idx];
    rd_hit    = slot_valid[rd_idx] && (slot_sqn[rd_idx] == bus.rd_sqn);
    rd_word   = slot_data[rd_idx];
`ifdef STDATA_BYPASS_EN
    // Higher lanes are visited last so they win, matching the array write order.
    for (int i = 0; i < WIDTH; i++) begin
      if (lane_live[i] && (stage_sqn[i] == head)) begin
        head_hit  = 1'b1;
        head_word = stage_data[i];
      end
      if (lane_live[i] && (stage_sqn[i] == bus.rd_sqn)) begin
        rd_hit  = 1'b1;
        rd_word = stage_data[i];
      end
    end
`endif
  end

  always_comb begin
    bus.head_sqn   = head;
    bus.head_valid = head_hit;
    bus.head_data  = head_hit ? head_word : '0;
    bus.rd_valid   = rd_hit;
    bus.rd_data    = rd_hit ? rd_word : 'x;
    bus.err        = err;
  end

  // A live write whose sqN is the head being retired this edge is consumed rather than re-stored.
  always_comb begin
    deq_fire = bus.deq && head_hit;
    err_set  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_write[i] = lane_live[i] && !(deq_fire && (stage_sqn[i] == head));
      if (stage_valid[i] && !lane_killed[i] && !in_window(stage_sqn[i], head)) begin
        err_set = 1'b1;
      end
      if (lane_live[i] && slot_valid[lane_slot[i]]) begin
        err_set = 1'b1;
      end
      for (int j = i + 1; j < WIDTH; j++) begin
        if (lane_live[i] && lane_live[j] && (lane_slot[i] == lane_slot[j])) begin
          err_set = 1'b1;
        end
      end
    end
  end

  // Order matters: branch kill and dequeue clear first, surviving stage writes then set valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid  <= '0;
      stage_valid <= '0;
      head        <= '0;
      err         <= 1'b0;
    end else begin
      for (int s = 0; s < SQ_SIZE; s++) begin
        if (slot_valid[s] &&
            is_killed(slot_sqn[s], bus.branch_taken, bus.branch_flush, bus.branch_sqn)) begin
          slot_valid[s] <= 1'b0;
        end
      end
      if (deq_fire) begin
        slot_valid[head_idx] <= 1'b0;
        head                 <= head + 1'b1;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (lane_write[i]) begin
          slot_valid[lane_slot[i]] <= 1'b1;
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        stage_valid[i] <= bus.uop_valid[i] &&
          !is_killed(bus.uop_sqn[i], bus.branch_taken, bus.branch_flush, bus.branch_sqn);
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: every read is qualified by a reset-cleared valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (lane_write[i]) begin
        slot_sqn[lane_slot[i]]  <= stage_sqn[i];
        slot_data[lane_slot[i]] <= stage_data[i];
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      stage_sqn[i]  <= bus.uop_sqn[i];
      stage_data[i] <= bus.uop_data[i];
    end
  end

endmodule
